// File: rtl/ft232h_sync_fifo_responder_pkg.sv
// Shared constants and types for the FT232H 245 synchronous-FIFO device model.
package ft232h_model_pkg;

  localparam int DATA_W = 8;

  // Bit positions inside proto_err.
  localparam int ERR_WR_TXE     = 0;
  localparam int ERR_RD_RXF     = 1;
  localparam int ERR_RD_NOOE    = 2;
  localparam int ERR_CONTENTION = 3;
  localparam int ERR_W          = 4;

  typedef enum logic {
    RUN = 1'b0,
    GAP = 1'b1
  } throttle_state_t;

endpackage

// File: rtl/ft232h_sync_fifo_responder_fifo.sv
// First-word fall-through synchronous FIFO with valid/ready on both sides and
// occupancy outputs (current and next-edge) for registered flag generation.
module sync_fifo_fwft #(
  parameter int DW   = 8,
  parameter int AEXP = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AEXP:0] count,
  output logic [AEXP:0] count_next
);

  localparam int DEPTH = 1 << AEXP;
  localparam logic [AEXP:0] FULL_CNT = (AEXP+1)'(DEPTH);

  logic [DW-1:0]   mem [DEPTH];
  logic [AEXP-1:0] wr_ptr;
  logic [AEXP-1:0] rd_ptr;
  logic            push;
  logic            pop;

  assign in_ready   = (count != FULL_CNT);
  assign out_valid  = (count != '0);
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign out_data   = mem[rd_ptr];
  assign count_next = count + (AEXP+1)'(push) - (AEXP+1)'(pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AEXP'(1);
      if (pop)  rd_ptr <= rd_ptr + AEXP'(1);
      count <= count_next;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/ft232h_sync_fifo_responder.sv
// Device-side FT232H 245 synchronous-FIFO model: host byte streams on one side,
// RXF#/TXE#/OE#/RD#/WR# bus on the other, with TX burst throttling and sticky errors.
module ft232h_sync_fifo_responder
  import ft232h_model_pkg::*;
#(
  parameter int AEXP     = 9,
  parameter int TX_BURST = 512,
  parameter int TX_GAP   = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              usb_rxf,
  output logic              usb_txe,
  input  logic              usb_oe,
  input  logic              usb_rd,
  input  logic              usb_wr,
  input  logic [DATA_W-1:0] usb_data_in,
  output logic [DATA_W-1:0] usb_data_out,
  output logic              usb_data_oe,
  input  logic              host_tx_valid,
  output logic              host_tx_ready,
  input  logic [DATA_W-1:0] host_tx_data,
  output logic              host_rx_valid,
  input  logic              host_rx_ready,
  output logic [DATA_W-1:0] host_rx_data,
  output logic [ERR_W-1:0]  proto_err
);

  localparam int DEPTH   = 1 << AEXP;
  localparam int BURST_W = $clog2(TX_BURST + 1);
  localparam int GAP_W   = (TX_GAP > 1) ? $clog2(TX_GAP + 1) : 1;
  localparam logic [AEXP:0] FULL_CNT = (AEXP+1)'(DEPTH);

  logic              rx_in_ready, rx_out_valid, rd_pop;
  logic [DATA_W-1:0] rx_head;
  logic [AEXP:0]     rx_count, rx_count_next;
  logic              tx_in_valid, tx_in_ready, wr_accept;
  logic [AEXP:0]     tx_count, tx_count_next;
  logic              ready_en;
  logic [ERR_W-1:0]  err_now;

  throttle_state_t   state, state_next;
  logic [BURST_W-1:0] wr_cnt, wr_cnt_next;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_next;

  // Host side is held off until the first edge after reset is released.
  assign host_tx_ready = ready_en & rx_in_ready;
  assign rd_pop        = ~usb_rd & ~usb_oe & ~usb_rxf;
  assign usb_data_out  = rx_out_valid ? rx_head : '0;

  sync_fifo_fwft #(.DW(DATA_W), .AEXP(AEXP)) u_rx_fifo (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (host_tx_valid & host_tx_ready),
    .in_ready   (rx_in_ready),
    .in_data    (host_tx_data),
    .out_valid  (rx_out_valid),
    .out_ready  (rd_pop),
    .out_data   (rx_head),
    .count      (rx_count),
    .count_next (rx_count_next)
  );

  assign tx_in_valid = ~usb_wr & ~usb_txe;
  assign wr_accept   = tx_in_valid & tx_in_ready;

  sync_fifo_fwft #(.DW(DATA_W), .AEXP(AEXP)) u_tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (tx_in_valid),
    .in_ready   (tx_in_ready),
    .in_data    (usb_data_in),
    .out_valid  (host_rx_valid),
    .out_ready  (host_rx_ready),
    .out_data   (host_rx_data),
    .count      (tx_count),
    .count_next (tx_count_next)
  );

  // Flags are registered from count_next; the plain counts are spare.
  logic unused_counts;
  assign unused_counts = ^{rx_count, tx_count};

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    wr_cnt_next  = wr_cnt;
    gap_cnt_next = gap_cnt;
    case (state)
      RUN: begin
        if (wr_accept && (TX_GAP != 0)) begin
          if (wr_cnt == BURST_W'(TX_BURST - 1)) begin
            state_next   = GAP;
            wr_cnt_next  = BURST_W'(TX_BURST);
            gap_cnt_next = GAP_W'(TX_GAP);
          end else begin
            wr_cnt_next = wr_cnt + BURST_W'(1);
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(1)) begin
          state_next   = RUN;
          wr_cnt_next  = '0;
          gap_cnt_next = '0;
        end else begin
          gap_cnt_next = gap_cnt - GAP_W'(1);
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    err_now                 = '0;
    err_now[ERR_WR_TXE]     = ~usb_wr & usb_txe;
    err_now[ERR_RD_RXF]     = ~usb_rd & ~usb_oe & usb_rxf;
    // usb_data_oe holds the inverted OE# of the previous edge.
    err_now[ERR_RD_NOOE]    = ~usb_rd & ~usb_data_oe;
    err_now[ERR_CONTENTION] = ~usb_wr & ~usb_oe;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      usb_rxf     <= 1'b1;
      usb_txe     <= 1'b1;
      usb_data_oe <= 1'b0;
      proto_err   <= '0;
      ready_en    <= 1'b0;
      state       <= RUN;
      wr_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      usb_rxf     <= (rx_count_next == '0);
      usb_txe     <= (tx_count_next == FULL_CNT) | (state_next == GAP);
      usb_data_oe <= ~usb_oe;
      proto_err   <= proto_err | err_now;
      ready_en    <= 1'b1;
      state       <= state_next;
      wr_cnt      <= wr_cnt_next;
      gap_cnt     <= gap_cnt_next;
    end
  end

endmodule

// File: tb/tb_ft232h_sync_fifo_responder.sv
// Directed bench for the FT232H FIFO responder: default instance plus a
// shallow (AEXP=4) instance for the full-FIFO case.
module tb_ft232h_sync_fifo_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       usb_rxf, usb_txe, usb_data_oe;
  logic       usb_oe = 1'b1, usb_rd = 1'b1, usb_wr = 1'b1;
  logic [7:0] usb_data_in = 8'h00, usb_data_out;
  logic       host_tx_valid = 1'b0, host_tx_ready;
  logic [7:0] host_tx_data = 8'h00, host_rx_data;
  logic       host_rx_valid, host_rx_ready = 1'b0;
  logic [3:0] proto_err;

  logic       s_rxf, s_txe, s_data_oe;
  logic       s_oe = 1'b1, s_rd = 1'b1, s_wr = 1'b1;
  logic [7:0] s_data_in = 8'h00, s_data_out;
  logic       s_tx_valid = 1'b0, s_tx_ready;
  logic [7:0] s_tx_data = 8'h00, s_rx_data;
  logic       s_rx_valid, s_rx_ready = 1'b0;
  logic [3:0] s_proto_err;

  ft232h_sync_fifo_responder dut (
    .clk(clk), .rst(rst), .usb_rxf(usb_rxf), .usb_txe(usb_txe),
    .usb_oe(usb_oe), .usb_rd(usb_rd), .usb_wr(usb_wr),
    .usb_data_in(usb_data_in), .usb_data_out(usb_data_out), .usb_data_oe(usb_data_oe),
    .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready), .host_tx_data(host_tx_data),
    .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready), .host_rx_data(host_rx_data),
    .proto_err(proto_err)
  );

  ft232h_sync_fifo_responder #(.AEXP(4)) dut_s (
    .clk(clk), .rst(rst), .usb_rxf(s_rxf), .usb_txe(s_txe),
    .usb_oe(s_oe), .usb_rd(s_rd), .usb_wr(s_wr),
    .usb_data_in(s_data_in), .usb_data_out(s_data_out), .usb_data_oe(s_data_oe),
    .host_tx_valid(s_tx_valid), .host_tx_ready(s_tx_ready), .host_tx_data(s_tx_data),
    .host_rx_valid(s_rx_valid), .host_rx_ready(s_rx_ready), .host_rx_data(s_rx_data),
    .proto_err(s_proto_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, rcv, nruns, n;
    int run_start[4];
    int run_len[4];
    logic prev_high;

    // Reset state
    repeat (3) tick();
    check("rst_rxf", 32'(usb_rxf), 32'd1);
    check("rst_txe", 32'(usb_txe), 32'd1);
    check("rst_data_oe", 32'(usb_data_oe), 32'd0);
    check("rst_data_out", 32'(usb_data_out), 32'h00);
    check("rst_tx_ready", 32'(host_tx_ready), 32'd0);
    check("rst_rx_valid", 32'(host_rx_valid), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_txe", 32'(usb_txe), 32'd0);
    check("post_rst_tx_ready", 32'(host_tx_ready), 32'd1);

    // Host pushes 0x00..0x0F, FPGA reads them back with OE# then RD#
    for (int i = 0; i < 16; i++) begin
      host_tx_valid = 1'b1;
      host_tx_data  = 8'(i);
      tick();
    end
    host_tx_valid = 1'b0;
    check("rx_rxf_low", 32'(usb_rxf), 32'd0);
    usb_oe = 1'b0;
    tick();
    check("rx_data_oe", 32'(usb_data_oe), 32'd1);
    usb_rd = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("rx_byte%0d", i), 32'(usb_data_out), 32'(i));
      if (i == 15) check("rx_rxf_before_last", 32'(usb_rxf), 32'd0);
      tick();
    end
    check("rx_rxf_after_last", 32'(usb_rxf), 32'd1);
    check("rx_empty_data", 32'(usb_data_out), 32'h00);
    usb_rd = 1'b1;
    usb_oe = 1'b1;
    tick();
    check("rx_proto_err", 32'(proto_err), 32'd0);

    // 1100 FPGA writes with burst throttling, host drains continuously
    host_rx_ready = 1'b1;
    sent = 0; rcv = 0; nruns = 0; prev_high = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (usb_txe) begin
        if (!prev_high && nruns < 4) begin
          run_start[nruns] = sent;
          run_len[nruns]   = 1;
          nruns++;
        end else if (prev_high && nruns > 0 && nruns <= 4) begin
          run_len[nruns-1]++;
        end
      end
      prev_high = usb_txe;
      if (host_rx_valid) begin
        if (host_rx_data !== 8'(rcv)) check($sformatf("tx_byte%0d", rcv), 32'(host_rx_data), 32'(8'(rcv)));
        rcv++;
      end
      if (!usb_txe && sent < 1100) begin
        usb_wr      = 1'b0;
        usb_data_in = 8'(sent);
        sent++;
      end else begin
        usb_wr = 1'b1;
      end
      if (sent == 1100 && rcv == 1100 && usb_wr) break;
      tick();
    end
    usb_wr = 1'b1;
    check("tx_sent", 32'(sent), 32'd1100);
    check("tx_received", 32'(rcv), 32'd1100);
    check("tx_gap_runs", 32'(nruns), 32'd2);
    if (nruns >= 2) begin
      check("tx_gap0_start", 32'(run_start[0]), 32'd512);
      check("tx_gap0_len", 32'(run_len[0]), 32'd8);
      check("tx_gap1_start", 32'(run_start[1]), 32'd1024);
      check("tx_gap1_len", 32'(run_len[1]), 32'd8);
    end
    check("tx_proto_err", 32'(proto_err), 32'd0);

    // Shallow instance: fill tx FIFO, then write while full
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("full_txe_before", 32'(s_txe), 32'd0);
      s_wr      = 1'b0;
      s_data_in = 8'(8'hA0 + i);
      tick();
    end
    check("full_txe_after", 32'(s_txe), 32'd1);
    s_data_in = 8'hEE;
    tick();
    check("full_proto_err", 32'(s_proto_err), 32'd1);
    s_wr       = 1'b1;
    s_rx_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (s_rx_valid) begin
        check($sformatf("full_byte%0d", n), 32'(s_rx_data), 32'(8'hA0 + n));
        n++;
      end
      tick();
    end
    check("full_drain_count", 32'(n), 32'd16);
    check("full_txe_drained", 32'(s_txe), 32'd0);

    // RD# low while OE# was high on the previous edge
    host_tx_valid = 1'b1;
    host_tx_data  = 8'h55;
    tick();
    host_tx_data  = 8'h66;
    tick();
    host_tx_valid = 1'b0;
    usb_rd = 1'b0;
    tick();
    usb_rd = 1'b1;
    check("noe_proto_err", 32'(proto_err), 32'b0100);
    check("noe_no_pop", 32'(usb_data_out), 32'h55);
    check("noe_rxf", 32'(usb_rxf), 32'd0);

    // Simultaneous push and pop at count 1
    usb_oe = 1'b0;
    tick();
    usb_rd = 1'b0;
    tick();
    check("sim_head_before", 32'(usb_data_out), 32'h66);
    host_tx_valid = 1'b1;
    host_tx_data  = 8'h77;
    tick();
    usb_rd = 1'b1;
    usb_oe = 1'b1;
    host_tx_valid = 1'b0;
    check("sim_rxf", 32'(usb_rxf), 32'd0);
    check("sim_head_after", 32'(usb_data_out), 32'h77);
    tick();
    check("sim_proto_err", 32'(proto_err), 32'b0100);

    // Reset with bytes queued in both FIFOs
    host_rx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      host_tx_valid = 1'b1;
      host_tx_data  = 8'(8'h80 + i);
      usb_wr        = usb_txe;
      usb_data_in   = 8'(i);
      tick();
    end
    host_tx_valid = 1'b0;
    usb_wr = 1'b1;
    check("pre_rst_rx_valid", 32'(host_rx_valid), 32'd1);
    check("pre_rst_rxf", 32'(usb_rxf), 32'd0);
    rst = 1'b1;
    tick();
    check("mid_rst_rxf", 32'(usb_rxf), 32'd1);
    check("mid_rst_rx_valid", 32'(host_rx_valid), 32'd0);
    check("mid_rst_txe", 32'(usb_txe), 32'd1);
    check("mid_rst_proto_err", 32'(proto_err), 32'd0);
    check("mid_rst_data_out", 32'(usb_data_out), 32'h00);
    rst = 1'b0;
    tick();
    check("rel_rst_txe", 32'(usb_txe), 32'd0);
    check("rel_rst_rxf", 32'(usb_rxf), 32'd1);
    check("rel_rst_tx_ready", 32'(host_tx_ready), 32'd1);
    check("rel_rst_rx_valid", 32'(host_rx_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
